// File: rtl/fifo_s1_param_if.sv
// Handshake and status bundle for the single-clock parameterised FIFO.
// The master side issues requests and data; the slave side is the FIFO itself.
interface fifo_s1_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                           push_req_n;
    logic                           pop_req_n;
    logic                           diag_n;
    logic [WIDTH-1:0]               data_in;
    logic [WIDTH-1:0]               data_out;
    logic                           empty;
    logic                           almost_empty;
    logic                           half_full;
    logic                           almost_full;
    logic                           full;
    logic                           error;
    logic [$clog2(DEPTH+1)-1:0]     word_count;

    modport master (
        output push_req_n, pop_req_n, diag_n, data_in,
        input  data_out, empty, almost_empty, half_full, almost_full, full, error, word_count
    );

    modport slave (
        input  push_req_n, pop_req_n, diag_n, data_in,
        output data_out, empty, almost_empty, half_full, almost_full, full, error, word_count
    );
endinterface

// File: rtl/fifo_s1_param.sv
// Single-clock FIFO with registered occupancy flags, sticky or per-cycle error,
// and either look-ahead or registered read data.
module fifo_s1_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AE_LEVEL = 1,
    parameter int AF_LEVEL = 1,
    parameter int ERR_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input logic             clk,
    input logic             rst_n,
    fifo_s1_param_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);
    localparam logic [CW-1:0] HF_LVL   = CW'((DEPTH + 1) / 2);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_LEVEL);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d, almost_empty_q, almost_empty_d;
    logic             half_full_q, half_full_d, almost_full_q, almost_full_d;
    logic             full_q, full_d, error_q, error_d;
    logic             push_s, pop_s, do_push_s, do_pop_s, ovf_s, unf_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Request decode: a pop on a full FIFO frees the slot for a same-cycle push.
    always_comb begin
        push_s    = ~bus.push_req_n;
        pop_s     = ~bus.pop_req_n;
        do_pop_s  = pop_s & ~empty_q;
        do_push_s = push_s & (~full_q | pop_s);
        ovf_s     = push_s & full_q & ~pop_s;
        unf_s     = pop_s & empty_q;
    end

    // Next pointer, occupancy, flag and error state.
    always_comb begin
        wr_ptr_d = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d        = (count_d == '0);
        almost_empty_d = (count_d <= AE_LVL);
        half_full_d    = (count_d >= HF_LVL);
        almost_full_d  = (count_d >= AF_LVL);
        full_d         = (count_d == FULL_LVL);
        if (ERR_MODE == 0) begin
            if (!bus.diag_n) begin
                error_d = 1'b0;
            end else begin
                error_d = error_q | ovf_s | unf_s;
            end
        end else begin
            error_d = ovf_s | unf_s;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            half_full_q    <= 1'b0;
            almost_full_q  <= 1'b0;
            full_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            half_full_q    <= half_full_d;
            almost_full_q  <= almost_full_d;
            full_q         <= full_d;
            error_q        <= error_d;
        end
    end

    // Storage array; contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    if (OUT_REG == 0) begin : g_lookahead
        assign bus.data_out = empty_q ? '0 : mem_q[rd_ptr_q];
    end else begin : g_regout
        logic [WIDTH-1:0] dout_q, dout_d;

        // Capture the popped word and hold it until the next successful pop.
        always_comb begin
            if (do_pop_s) begin
                dout_d = mem_q[rd_ptr_q];
            end else begin
                dout_d = dout_q;
            end
        end

        // Registered read data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign bus.data_out = dout_q;
    end

    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.half_full    = half_full_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.full         = full_q;
    assign bus.error        = error_q;
    assign bus.word_count   = count_q;
endmodule

// File: tb/tb_fifo_s1_param.sv
// Scoreboard bench: two FIFO configurations share one stimulus stream and are
// compared each cycle against a list-based reference model.
module tb_fifo_s1_param;
    typedef struct {
        int         cnt;
        bit         emp, ae, hf, af, ful, err, dv;
        logic [7:0] dout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push_n, pop_n, diag_n;
    logic [7:0] din;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    fifo_s1_param_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
    fifo_s1_param_if #(.WIDTH(8), .DEPTH(5)) bus_b ();

    assign bus_a.push_req_n = push_n;
    assign bus_a.pop_req_n  = pop_n;
    assign bus_a.diag_n     = diag_n;
    assign bus_a.data_in    = din;
    assign bus_b.push_req_n = push_n;
    assign bus_b.pop_req_n  = pop_n;
    assign bus_b.diag_n     = diag_n;
    assign bus_b.data_in    = din;

    fifo_s1_param #(.WIDTH(8), .DEPTH(4), .AE_LEVEL(1), .AF_LEVEL(1),
                    .ERR_MODE(0), .OUT_REG(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    fifo_s1_param #(.WIDTH(8), .DEPTH(5), .AE_LEVEL(2), .AF_LEVEL(2),
                    .ERR_MODE(1), .OUT_REG(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    // Reference model: an ordered list per configuration, head at index 0.
    int         cfg_d  [2] = '{4, 5};
    int         cfg_ae [2] = '{1, 2};
    int         cfg_af [2] = '{1, 2};
    int         cfg_em [2] = '{0, 1};
    int         cfg_or [2] = '{0, 1};
    logic [7:0] mstore [2][256];
    int         mcnt   [2];
    bit         merr   [2];
    logic [7:0] mlast  [2];
    exp_t       exp_a[$], exp_b[$];

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %0d want %0d at %0t", tag, nm, act, req, $time);
        end
    endtask

    task automatic check_obs(input string tag, input exp_t e, input logic [31:0] cnt,
                             input logic emp, input logic ae, input logic hf, input logic af,
                             input logic ful, input logic err, input logic [7:0] dout);
        chk(tag, "word_count",   cnt,        32'(e.cnt));
        chk(tag, "empty",        32'(emp),   32'(e.emp));
        chk(tag, "almost_empty", 32'(ae),    32'(e.ae));
        chk(tag, "half_full",    32'(hf),    32'(e.hf));
        chk(tag, "almost_full",  32'(af),    32'(e.af));
        chk(tag, "full",         32'(ful),   32'(e.ful));
        chk(tag, "error",        32'(err),   32'(e.err));
        if (e.dv) begin
            chk(tag, "data_out", 32'(dout), 32'(e.dout));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]  = 0;
            merr[k]  = 1'b0;
            mlast[k] = 8'd0;
        end
    endtask

    task automatic model_edge(input int id, input bit push, input bit pop, input bit diag, input logic [7:0] d);
        int   n;
        bit   emp, ful, unf, ovf;
        exp_t e;
        n   = mcnt[id];
        emp = (n == 0);
        ful = (n == cfg_d[id]);
        unf = pop && emp;
        ovf = push && ful && !pop;
        if (pop && !emp) begin
            if (cfg_or[id] == 1) mlast[id] = mstore[id][0];
            for (int i = 0; i < n - 1; i++) mstore[id][i] = mstore[id][i+1];
            n--;
        end
        if (push && (!ful || pop)) begin
            mstore[id][n] = d;
            n++;
        end
        mcnt[id] = n;
        if (cfg_em[id] == 0) merr[id] = diag ? 1'b0 : (merr[id] | unf | ovf);
        else                 merr[id] = unf | ovf;
        e.cnt = n;
        e.emp = (n == 0);
        e.ae  = (n <= cfg_ae[id]);
        e.hf  = (n >= (cfg_d[id] + 1) / 2);
        e.af  = (n >= cfg_d[id] - cfg_af[id]);
        e.ful = (n == cfg_d[id]);
        e.err = merr[id];
        if (cfg_or[id] == 1) begin
            e.dv   = 1'b1;
            e.dout = mlast[id];
        end else begin
            e.dv   = (n > 0);
            e.dout = mstore[id][0];
        end
        if (id == 0) exp_a.push_back(e);
        else         exp_b.push_back(e);
    endtask

    task automatic step(input bit push, input bit pop, input bit diag, input logic [7:0] d);
        push_n = ~push;
        pop_n  = ~pop;
        diag_n = ~diag;
        din    = d;
        @(posedge clk);
        model_edge(0, push, pop, diag, d);
        model_edge(1, push, pop, diag, d);
        #1;
        push_n = 1'b1;
        pop_n  = 1'b1;
        diag_n = 1'b1;
    endtask

    task automatic check_reset_now(input string tag);
        exp_t r;
        r = '{cnt: 0, emp: 1'b1, ae: 1'b1, hf: 1'b0, af: 1'b0, ful: 1'b0, err: 1'b0, dv: 1'b1, dout: 8'd0};
        check_obs({tag, ".A"}, r, 32'(bus_a.word_count), bus_a.empty, bus_a.almost_empty,
                  bus_a.half_full, bus_a.almost_full, bus_a.full, bus_a.error, bus_a.data_out);
        check_obs({tag, ".B"}, r, 32'(bus_b.word_count), bus_b.empty, bus_b.almost_empty,
                  bus_b.half_full, bus_b.almost_full, bus_b.full, bus_b.error, bus_b.data_out);
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next clock edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_now(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare each DUT against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t ea, eb;
        if (exp_a.size() > 0) begin
            ea = exp_a.pop_front();
            check_obs("A", ea, 32'(bus_a.word_count), bus_a.empty, bus_a.almost_empty,
                      bus_a.half_full, bus_a.almost_full, bus_a.full, bus_a.error, bus_a.data_out);
        end
        if (exp_b.size() > 0) begin
            eb = exp_b.pop_front();
            check_obs("B", eb, 32'(bus_b.word_count), bus_b.empty, bus_b.almost_empty,
                      bus_b.half_full, bus_b.almost_full, bus_b.full, bus_b.error, bus_b.data_out);
        end
    end

    initial begin
        bit         p, q, g;
        int         bias;
        logic [7:0] seq_a [4];
        seq_a = '{8'd5, 8'd2, 8'd3, 8'd4};
        rst_n  = 1'b1;
        push_n = 1'b1;
        pop_n  = 1'b1;
        diag_n = 1'b1;
        din    = 8'd0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_now("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then overflow with 9 and drain.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, seq_a[i]);
        step(1'b1, 1'b0, 1'b0, 8'd9);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 8'd0);

        // Refill, push 7 with a same-cycle pop on a full FIFO, drain.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, seq_a[i]);
        step(1'b1, 1'b1, 1'b0, 8'd7);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 8'd0);

        // Push 6 and pop together while empty: push wins, pop underflows.
        step(1'b1, 1'b1, 1'b0, 8'd6);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 8'd0);

        // Push 1..5, seven pops with a push of 8 after the third.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0);
            if (i == 2) step(1'b1, 1'b0, 1'b0, 8'd8);
        end

        // Three words stored, then asynchronous reset; first push becomes head.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        async_reset("rst3");
        step(1'b1, 1'b0, 1'b0, 8'hA1);
        step(1'b0, 1'b1, 1'b0, 8'd0);

        // Randomised traffic with alternating fill/drain bias.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset("rstr");
            bias = ((i / 40) % 2 == 1) ? 75 : 30;
            p = ($urandom_range(99) < bias);
            q = ($urandom_range(99) < (100 - bias));
            g = ($urandom_range(15) == 0);
            step(p, q, g, 8'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        chk("end", "pending_A", 32'(exp_a.size()), 32'd0);
        chk("end", "pending_B", 32'(exp_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_s1_param.md
FIFO_S1_PARAM -- requirements
Module: fifo_s1_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (1..256).
REQ-002 The block SHALL have parameter DEPTH, default 4, word capacity (2..256; non-power-of-2 allowed).
REQ-003 The block SHALL have parameter AE_LEVEL, default 1, almost_empty threshold (1..DEPTH-1).
REQ-004 The block SHALL have parameter AF_LEVEL, default 1, almost_full threshold (1..DEPTH-1).
REQ-005 The block SHALL have parameter ERR_MODE, default 0: 0 = sticky error, 1 = per-cycle error.
REQ-006 The block SHALL have parameter OUT_REG, default 0: 0 = look-ahead head word on data_out, 1 = registered read with 1-cycle latency.
REQ-007 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-008 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 The block SHALL have port push_req_n  input  1  active-low write request.
REQ-010 The block SHALL have port pop_req_n  input  1  active-low read request.
REQ-011 The block SHALL have port diag_n  input  1  active-low synchronous clear of sticky error.
REQ-012 The block SHALL have port data_in  input  WIDTH  write data.
REQ-013 The block SHALL have outputs empty, almost_empty, half_full, almost_full, full, error, each 1 bit.
REQ-014 The block SHALL have port data_out  output  WIDTH  read data.
REQ-015 The block SHALL have port word_count  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-016 The block SHALL write data_in at wr_ptr when push_req_n=0 and full=0, or when push_req_n=0, pop_req_n=0 and full=1 (pop frees the slot in the same cycle).
REQ-017 The block SHALL pop the head word when pop_req_n=0 and empty=0; a pop while empty SHALL be an underflow, leaving state unchanged.
REQ-018 A push while full without a simultaneous pop SHALL be an overflow: data dropped, state unchanged.
REQ-019 When push and pop are both requested with empty=1, the push SHALL proceed and the pop SHALL be flagged underflow.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0; word_count SHALL change by +1, -1 or 0 per cycle and never exceed DEPTH.
REQ-021 Flags SHALL be: empty = (count==0); almost_empty = (count<=AE_LEVEL); half_full = (count>=(DEPTH+1)/2); almost_full = (count>=DEPTH-AF_LEVEL); full = (count==DEPTH). Flags SHALL be registered and valid in the cycle after the causing edge.
REQ-022 With OUT_REG=0, data_out SHALL combinationally show the head word (don't-care when empty) and advance the cycle after a pop.
REQ-023 With OUT_REG=1, data_out SHALL load the popped word on the pop edge and hold it until the next successful pop.
REQ-024 With ERR_MODE=0, error SHALL set on the edge following any overflow/underflow and stay high until reset or diag_n=0 (diag_n=0 SHALL take precedence over a same-cycle new error).
REQ-025 With ERR_MODE=1, error SHALL be high for exactly the cycle after each offending request; diag_n SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL immediately clear pointers, word_count=0, empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0, data_out=0; memory contents need not be cleared.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; the first push after release SHALL become the head.

Verification
REQ-028 DEPTH=4, OUT_REG=0: push 5,2,3,4 -> full=1, word_count=4, almost_full=1 after the 3rd push; data_out=5 from the cycle after the first push.
REQ-029 Full FIFO, push 9 without pop -> error=1 next cycle (ERR_MODE=0 stays high); pops yield 5,2,3,4, then empty=1.
REQ-030 Full FIFO, simultaneous push 7 and pop -> word_count stays 4, error=0; the subsequent four pops yield 2,3,4,7.
REQ-031 Empty FIFO, simultaneous push 6 and pop -> word_count=1, head=6, error asserted (underflow); ERR_MODE=1 -> error high for exactly one cycle.
REQ-032 DEPTH=5, OUT_REG=1: push 1..5, pop 7 times with a push of 8 after the 3rd pop -> data_out shows each popped word one cycle after its pop, correct across pointer wrap; underflow flagged.
REQ-033 rst_n=0 asserted asynchronously with 3 words stored -> all outputs take reset values before the next clock edge.
